// File: rtl/lsu_pkg.sv
// Shared types and decoder codes for the load/store unit.
// The store-width and load-select codes are the decoder's existing `EXE_* values.
`ifndef EXE_MEMWDSRC_B
`define EXE_MEMWDSRC_B        2'd0
`define EXE_MEMWDSRC_H        2'd1
`define EXE_MEMWDSRC_W        2'd2
`define EXE_DATAOUTSRC_RD32   3'd0
`define EXE_DATAOUTSRC_RDS8   3'd1
`define EXE_DATAOUTSRC_RDS16  3'd2
`define EXE_DATAOUTSRC_RDZ8   3'd3
`define EXE_DATAOUTSRC_RDZ16  3'd4
`endif

package lsu_pkg;
    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} lsu_state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

    // Unknown codes fall back to a full word.
    function automatic lsu_size_t st_size(input logic [1:0] wdsrc);
        case (wdsrc)
            `EXE_MEMWDSRC_B: return SZ_B;
            `EXE_MEMWDSRC_H: return SZ_H;
            default:         return SZ_W;
        endcase
    endfunction

    function automatic lsu_size_t ld_size(input logic [2:0] ldsrc);
        case (ldsrc)
            `EXE_DATAOUTSRC_RDS8,  `EXE_DATAOUTSRC_RDZ8:  return SZ_B;
            `EXE_DATAOUTSRC_RDS16, `EXE_DATAOUTSRC_RDZ16: return SZ_H;
            default:                                      return SZ_W;
        endcase
    endfunction
endpackage

// File: rtl/lsu_if.sv
// Request/response and data-memory bus of the load/store unit.
interface lsu_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_wdsrc;
    logic [2:0]        req_ldsrc;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_we, req_wdsrc, req_ldsrc, req_addr, req_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, mem_req, mem_addr, mem_we, mem_be, mem_wdata,
               rsp_valid, rsp_rdata, rsp_err
    );
    modport master (
        output req_valid, req_we, req_wdsrc, req_ldsrc, req_addr, req_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, mem_req, mem_addr, mem_we, mem_be, mem_wdata,
               rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store replication, load extraction/extension.
// With LSU_MISALIGN_TRAP_EN defined it also flags misaligned requests.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_we,
    input  logic [1:0]        i_wdsrc,
    input  logic [2:0]        i_ldsrc,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [2:0]        i_rd_ldsrc,
    input  logic [1:0]        i_rd_off,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [1:0]        o_off,
    output logic [3:0]        o_be,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_rdata
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              o_misalign
`endif
);
    lsu_size_t          w_size;
    logic [DATA_W-1:0]  w_sh;
    logic signed [7:0]  w_b8;
    logic signed [15:0] w_h16;

    assign w_size = i_we ? st_size(i_wdsrc) : ld_size(i_ldsrc);

    // Halfwords and words drop the low address bits they cannot use.
    always_comb begin
        o_off = 2'b00;
        case (w_size)
            SZ_B:    o_off = i_addr_lo;
            SZ_H:    o_off = {i_addr_lo[1], 1'b0};
            default: o_off = 2'b00;
        endcase
    end

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        if (i_we) begin
            case (w_size)
                SZ_B: begin
                    o_be    = 4'b0001 << o_off;
                    o_wdata = {LANES{i_wdata[LANE_W-1:0]}};
                end
                SZ_H: begin
                    o_be    = 4'b0011 << o_off;
                    o_wdata = {2{i_wdata[2*LANE_W-1:0]}};
                end
                default: begin
                    o_be    = 4'b1111;
                    o_wdata = i_wdata;
                end
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign o_misalign = ((w_size == SZ_H) && i_addr_lo[0]) ||
                        ((w_size == SZ_W) && (i_addr_lo != 2'b00));
`endif

    assign w_sh  = i_rdata >> {i_rd_off, 3'b000};
    assign w_b8  = w_sh[7:0];
    assign w_h16 = w_sh[15:0];

    always_comb begin
        o_rdata = w_sh;
        case (i_rd_ldsrc)
            `EXE_DATAOUTSRC_RDS8:  o_rdata = DATA_W'(w_b8);
            `EXE_DATAOUTSRC_RDS16: o_rdata = DATA_W'(w_h16);
            `EXE_DATAOUTSRC_RDZ8:  o_rdata = DATA_W'(w_sh[7:0]);
            `EXE_DATAOUTSRC_RDZ16: o_rdata = DATA_W'(w_sh[15:0]);
            default:               o_rdata = w_sh;
        endcase
    end
endmodule

// File: rtl/lsu.sv
// Load/store unit: one accepted op becomes a single-beat req/gnt/rvalid memory transaction.
// Define LSU_MISALIGN_TRAP_EN to complete misaligned accesses with rsp_err instead of truncating.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic rst,
    lsu_if.slave bus
);
    lsu_state_t        r_state;
    logic              r_ready;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [2:0]        r_ldsrc;
    logic [1:0]        r_off;
    logic [1:0]        w_off;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_ld;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              w_misalign;
    logic              r_rsp_err;
`endif

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .i_we       (bus.req_we),
        .i_wdsrc    (bus.req_wdsrc),
        .i_ldsrc    (bus.req_ldsrc),
        .i_addr_lo  (bus.req_addr[1:0]),
        .i_wdata    (bus.req_wdata),
        .i_rd_ldsrc (r_ldsrc),
        .i_rd_off   (r_off),
        .i_rdata    (bus.mem_rdata),
        .o_off      (w_off),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_ld)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .o_misalign (w_misalign)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_ldsrc     <= `EXE_DATAOUTSRC_RD32;
            r_off       <= 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_ready     <= 1'b0;
                        r_ldsrc     <= bus.req_ldsrc;
                        r_off       <= w_off;
                        r_rsp_rdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        r_rsp_err   <= w_misalign;
                        if (w_misalign) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                        end else
`endif
                        begin
                            r_state     <= REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.req_we;
                            r_mem_be    <= w_be;
                            r_mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) begin
                        r_mem_req <= 1'b0;
                        if (r_mem_we) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (bus.mem_rvalid) begin
                        r_rsp_rdata <= w_ld;
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.rsp_err   = r_rsp_err;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_lsu.sv
// Vector table plus scoreboard bench for lsu; expectations follow LSU_MISALIGN_TRAP_EN.
`ifndef EXE_MEMWDSRC_B
`define EXE_MEMWDSRC_B        2'd0
`define EXE_MEMWDSRC_H        2'd1
`define EXE_MEMWDSRC_W        2'd2
`define EXE_DATAOUTSRC_RD32   3'd0
`define EXE_DATAOUTSRC_RDS8   3'd1
`define EXE_DATAOUTSRC_RDS16  3'd2
`define EXE_DATAOUTSRC_RDZ8   3'd3
`define EXE_DATAOUTSRC_RDZ16  3'd4
`endif

module tb_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        we;
        logic [1:0]  wdsrc;
        logic [2:0]  ldsrc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        logic        mem;
        logic [31:0] eaddr;
        logic [3:0]  ebe;
        logic [31:0] ewdata;
        logic [31:0] erdata;
        logic        eerr;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] wdsrc, input logic [2:0] ldsrc,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                                input int gnt_dly, input logic mem, input logic [31:0] eaddr,
                                input logic [3:0] ebe, input logic [31:0] ewdata,
                                input logic [31:0] erdata, input logic eerr);
        vec_t v;
        v.we = we; v.wdsrc = wdsrc; v.ldsrc = ldsrc; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.gnt_dly = gnt_dly; v.mem = mem; v.eaddr = eaddr; v.ebe = ebe;
        v.ewdata = ewdata; v.erdata = erdata; v.eerr = eerr;
        return v;
    endfunction

    // Response monitor: every rsp_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_err", bus.rsp_err, e.err);
                check("rsp_latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   waited;
        @(negedge clk);
        waited = 0;
        while (bus.req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_wdsrc = v.wdsrc;
        bus.req_ldsrc = v.ldsrc;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        e.rdata = v.erdata;
        e.err   = v.eerr;
        e.acc   = cyc;
        e.lat   = v.mem ? ((v.we ? 2 : 3) + v.gnt_dly) : 1;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        bus.req_wdata = $urandom;
        if (v.mem) begin
            @(negedge clk);
            waited = 0;
            while (bus.mem_req !== 1'b1 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            check("mem_req_seen", bus.mem_req, 1'b1);
            for (int k = 0; k <= v.gnt_dly; k++) begin
                check("mem_out_hold",
                      {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, v.we ? bus.mem_wdata : 32'h0},
                      {1'b1, v.we, v.ebe, v.eaddr, v.we ? v.ewdata : 32'h0});
                check("req_ready_busy", bus.req_ready, 1'b0);
                if (k == v.gnt_dly) bus.mem_gnt = 1'b1;
                else @(negedge clk);
            end
            @(posedge clk);
            #1 bus.mem_gnt = 1'b0;
            if (!v.we) begin
                @(negedge clk);
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = v.rdata;
                @(posedge clk);
                #1 bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = $urandom;
            end
        end else begin
            @(negedge clk);
            check("no_mem_req", bus.mem_req, 1'b0);
        end
        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(posedge clk);
            #1 waited++;
        end
        if (sb.size() != 0) begin
            check("rsp_timeout", 1'b0, 1'b1);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_wdsrc  = `EXE_MEMWDSRC_W;
        bus.req_ldsrc  = `EXE_DATAOUTSRC_RD32;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'hDEAD_0BAD;

        // Vector table: {we, wdsrc, ldsrc, addr, wdata, rdata, gnt_dly, mem, eaddr, ebe, ewdata, erdata, eerr}
        vecs.push_back(mk(1, `EXE_MEMWDSRC_B, `EXE_DATAOUTSRC_RD32, 32'h1003, 32'h0000_00A5, 0, 0, 1, 32'h1000, 4'b1000, 32'hA5A5_A5A5, 0, 0));
        vecs.push_back(mk(0, `EXE_MEMWDSRC_W, `EXE_DATAOUTSRC_RDS8, 32'h2001, 0, 32'h0000_80FF, 0, 1, 32'h2000, 4'b1111, 0, 32'hFFFF_FF80, 0));
        vecs.push_back(mk(0, `EXE_MEMWDSRC_W, `EXE_DATAOUTSRC_RDZ8, 32'h2001, 0, 32'h0000_80FF, 0, 1, 32'h2000, 4'b1111, 0, 32'h0000_0080, 0));
        vecs.push_back(mk(0, `EXE_MEMWDSRC_W, `EXE_DATAOUTSRC_RDS16, 32'h2002, 0, 32'h8001_0000, 0, 1, 32'h2000, 4'b1111, 0, 32'hFFFF_8001, 0));
        vecs.push_back(mk(0, `EXE_MEMWDSRC_W, `EXE_DATAOUTSRC_RDZ16, 32'h2002, 0, 32'h8001_0000, 0, 1, 32'h2000, 4'b1111, 0, 32'h0000_8001, 0));
        vecs.push_back(mk(1, `EXE_MEMWDSRC_W, `EXE_DATAOUTSRC_RD32, 32'h4000, 32'hDEAD_BEEF, 0, 3, 1, 32'h4000, 4'b1111, 32'hDEAD_BEEF, 0, 0));
        vecs.push_back(mk(1, `EXE_MEMWDSRC_H, `EXE_DATAOUTSRC_RD32, 32'h5002, 32'h1234_ABCD, 0, 0, 1, 32'h5000, 4'b1100, 32'hABCD_ABCD, 0, 0));
        vecs.push_back(mk(1, `EXE_MEMWDSRC_H, `EXE_DATAOUTSRC_RD32, 32'h5000, 32'h1234_ABCD, 0, 1, 1, 32'h5000, 4'b0011, 32'hABCD_ABCD, 0, 0));
        vecs.push_back(mk(1, `EXE_MEMWDSRC_B, `EXE_DATAOUTSRC_RD32, 32'h6001, 32'hFFFF_FF77, 0, 0, 1, 32'h6000, 4'b0010, 32'h7777_7777, 0, 0));
        vecs.push_back(mk(0, `EXE_MEMWDSRC_B, `EXE_DATAOUTSRC_RD32, 32'h7000, 0, 32'hCAFE_F00D, 2, 1, 32'h7000, 4'b1111, 0, 32'hCAFE_F00D, 0));
        vecs.push_back(mk(0, `EXE_MEMWDSRC_W, `EXE_DATAOUTSRC_RDS8, 32'h2003, 0, 32'h7F00_0000, 0, 1, 32'h2000, 4'b1111, 0, 32'h0000_007F, 0));
        vecs.push_back(mk(0, `EXE_MEMWDSRC_W, `EXE_DATAOUTSRC_RDZ16, 32'h2000, 0, 32'h1234_FFFF, 0, 1, 32'h2000, 4'b1111, 0, 32'h0000_FFFF, 0));
        vecs.push_back(mk(1, 2'd3, `EXE_DATAOUTSRC_RD32, 32'h8000, 32'h0102_0304, 0, 0, 1, 32'h8000, 4'b1111, 32'h0102_0304, 0, 0));
        vecs.push_back(mk(0, `EXE_MEMWDSRC_W, 3'd7, 32'h8004, 0, 32'h8765_4321, 0, 1, 32'h8004, 4'b1111, 0, 32'h8765_4321, 0));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(0, `EXE_MEMWDSRC_W, `EXE_DATAOUTSRC_RD32, 32'h3002, 0, 32'h1122_3344, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, `EXE_MEMWDSRC_H, `EXE_DATAOUTSRC_RD32, 32'h5003, 32'h0000_BEEF, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, `EXE_MEMWDSRC_W, `EXE_DATAOUTSRC_RDS16, 32'h2001, 0, 32'h1122_3344, 0, 0, 0, 0, 0, 0, 1));
`else
        vecs.push_back(mk(0, `EXE_MEMWDSRC_W, `EXE_DATAOUTSRC_RD32, 32'h3002, 0, 32'h1122_3344, 0, 1, 32'h3000, 4'b1111, 0, 32'h1122_3344, 0));
        vecs.push_back(mk(1, `EXE_MEMWDSRC_H, `EXE_DATAOUTSRC_RD32, 32'h5003, 32'h0000_BEEF, 0, 0, 1, 32'h5000, 4'b1100, 32'hBEEF_BEEF, 0, 0));
        vecs.push_back(mk(0, `EXE_MEMWDSRC_W, `EXE_DATAOUTSRC_RDS16, 32'h2001, 0, 32'h1122_3344, 0, 1, 32'h2000, 4'b1111, 0, 32'h0000_3344, 0));
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {bus.req_ready, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err},
              {1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0});
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Reset while waiting for read data; the late rvalid must be dropped.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_ldsrc = `EXE_DATAOUTSRC_RD32;
        bus.req_addr  = 32'h9000;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst_seq_mem_req", bus.mem_req, 1'b1);
        bus.mem_gnt = 1'b1;
        @(posedge clk);
        #1 bus.mem_gnt = 1'b0;
        @(negedge clk);
        check("rst_seq_wait_ready", bus.req_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_seq_idle", {bus.req_ready, bus.mem_req, bus.rsp_valid}, {1'b1, 1'b0, 1'b0});
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h5555_AAAA;
        @(posedge clk);
        #1 bus.mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_seq_quiet", {bus.req_ready, bus.mem_req, bus.rsp_valid}, {1'b1, 1'b0, 1'b0});
        end

        // Normal operation resumes after the mid-transaction reset.
        run_vec(mk(0, `EXE_MEMWDSRC_W, `EXE_DATAOUTSRC_RDS8, 32'hA002, 0, 32'h0080_0000, 1, 1, 32'hA000, 4'b1111, 0, 32'hFFFF_FF80, 0));

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
